// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge and the models that drive it.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned APB_DEFAULT_TIMEOUT = 16;

    // Register-bank slave map
    localparam logic [3:0] REG0 = 4'h0;
    localparam logic [3:0] REG1 = 4'h4;
    localparam logic [3:0] REG2 = 4'h8;
    localparam logic [3:0] REG3 = 4'hC;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter; flags the last cycle a transfer may stay in ACCESS.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic TIMEOUT_ON = (TIMEOUT_CYCLES > 0);

    logic [CW-1:0] count;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // A ready slave on the LAST cycle still wins; the FSM checks PREADY first.
    assign expired = TIMEOUT_ON && (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request/response front end driving single APB3 transfers with a wait-state timeout.
//
//   state  | meaning
//   IDLE   | req_ready=1, waiting for a request
//   SETUP  | PSEL=1, PENABLE=0, one cycle
//   ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
//   RESP   | rsp_valid=1, holding response until rsp_ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    apb_state_e            state_q, state_d;
    logic                  psel_d, penable_d, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_d;
    logic                  rsp_valid_d, rsp_error_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  accept;
    logic                  wait_expired;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clear   (accept),
        .enable  ((state_q == ACCESS) && !PREADY),
        .expired (wait_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_error <= rsp_error_d;
        end
    end

    // Address/direction/data hold their last values after a transfer ends.
    always_comb begin
        state_d     = state_q;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_error_d = rsp_error;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_write ? req_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (PREADY) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    rsp_error_d = 1'b0;
                end else if (wait_expired) begin
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios then random transfers against a shadow register map.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int unsigned TO = APB_DEFAULT_TIMEOUT;

    logic        PCLK, PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] slave_mem [4] = '{default: 32'h0};
    logic [31:0] shadow    [4];

    apb_master_bridge #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Register-bank slave: four word registers, everything else reads 0.
    assign PRDATA = (PADDR[1:0] == 2'b00) ? slave_mem[PADDR[3:2]] : 32'h0;
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE && PADDR[1:0] == 2'b00)
            slave_mem[PADDR[3:2]] <= PWDATA;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        if (addr[1:0] != 2'b00) return 32'h0;
        return shadow[addr[3:2]];
    endfunction

    // One full transfer: waits = ACCESS cycles with PREADY low before it rises,
    // rsp_hold = cycles rsp_ready stays low while a stray request is offered.
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input int waits, input int rsp_hold);
        logic        err;
        int          len;
        logic [31:0] exp_rd, exp_wd;
        err    = (TO > 0) && (waits >= int'(TO));
        len    = err ? int'(TO) : waits + 1;
        exp_rd = (wr || err) ? 32'h0 : model_read(addr);
        exp_wd = wr ? wd : 32'h0;

        chk("req_ready_idle", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b0; req_write = ~wr; req_addr = 4'($urandom); req_wdata = $urandom;
        chk("setup_psel", 32'(PSEL), 32'h1);
        chk("setup_penable", 32'(PENABLE), 32'h0);
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        chk("setup_paddr", 32'(PADDR), 32'(addr));
        chk("setup_pwdata", PWDATA, exp_wd);
        chk("setup_req_ready", 32'(req_ready), 32'h0);
        @(negedge PCLK);
        for (int k = 0; k < len; k++) begin
            chk("access_sel_en", {30'h0, PSEL, PENABLE}, 32'h3);
            chk("access_paddr", 32'(PADDR), 32'(addr));
            chk("access_pwdata", PWDATA, exp_wd);
            chk("access_rsp_valid", 32'(rsp_valid), 32'h0);
            PREADY = (k >= waits);
            @(negedge PCLK);
        end
        PREADY = 1'b0;
        chk("resp_valid", 32'(rsp_valid), 32'h1);
        chk("resp_sel_en", {30'h0, PSEL, PENABLE}, 32'h0);
        chk("resp_error", 32'(rsp_error), 32'(err));
        chk("resp_rdata", rsp_rdata, exp_rd);
        chk("resp_paddr_kept", 32'(PADDR), 32'(addr));
        if (!err && wr && addr[1:0] == 2'b00) shadow[addr[3:2]] = wd;

        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'($urandom); req_wdata = $urandom;
        for (int h = 0; h < rsp_hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge PCLK);
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_error", 32'(rsp_error), 32'(err));
            chk("hold_req_ready", 32'(req_ready), 32'h0);
            chk("hold_psel", 32'(PSEL), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        chk("handshake_valid", 32'(rsp_valid), 32'h0);
        chk("handshake_req_ready", 32'(req_ready), 32'h1);
        chk("handshake_no_accept", 32'(PSEL), 32'h0);
        req_valid = 1'b0;
    endtask

    // Reset pulse in ACCESS (phase 0) or while a response is pending (phase 1).
    task automatic reset_mid(input int phase);
        req_valid = 1'b1; req_write = 1'b0; req_addr = REG2; PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        if (phase == 1) begin
            PREADY = 1'b1;
            @(negedge PCLK);
            PREADY = 1'b0;
            chk("rst_pre_valid", 32'(rsp_valid), 32'h1);
        end else begin
            chk("rst_pre_access", {30'h0, PSEL, PENABLE}, 32'h3);
        end
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_async_sel_en", {30'h0, PSEL, PENABLE}, 32'h0);
        chk("rst_async_valid", 32'(rsp_valid), 32'h0);
        chk("rst_async_req_ready", 32'(req_ready), 32'h1);
        chk("rst_async_rdata", rsp_rdata, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("rst_after_req_ready", 32'(req_ready), 32'h1);
        chk("rst_after_valid", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) shadow[i] = 32'h0;
        PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'h0;
        req_wdata = 32'h0; rsp_ready = 1'b0; PREADY = 1'b0;
        #3;
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_sel_en_wr", {29'h0, PSEL, PENABLE, PWRITE}, 32'h0);
        chk("reset_paddr", 32'(PADDR), 32'h0);
        chk("reset_pwdata", PWDATA, 32'h0);
        chk("reset_rsp", {31'h0, rsp_valid} | 32'(rsp_error) | rsp_rdata, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        xfer(1'b1, REG1, 32'hDEADBEEF, 0, 0);
        xfer(1'b0, REG1, 32'h0, 0, 0);
        xfer(1'b0, 4'h2, 32'h0, 0, 0);
        xfer(1'b0, REG2, 32'h0, 3, 0);
        xfer(1'b0, REG3, 32'h0, 1000, 0);
        xfer(1'b0, REG1, 32'h0, int'(TO) - 1, 0);
        xfer(1'b1, REG0, 32'h12345678, int'(TO), 0);
        xfer(1'b0, REG0, 32'h0, 0, 0);
        xfer(1'b0, REG1, 32'h0, 0, 5);

        reset_mid(0);
        xfer(1'b1, REG3, 32'hCAFEF00D, 0, 0);
        xfer(1'b0, REG3, 32'h0, 1, 0);
        reset_mid(1);
        xfer(1'b0, REG3, 32'h0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                            : int'($urandom_range(0, 4));
            xfer(1'($urandom), 4'($urandom_range(0, 15)), $urandom, w, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
